path_executor: RTL and testbench

- Initiator and consumer on the planner side of the path-planning interface (start, s_node, e_node in; done, final_path out).
- Takes a goal node from the mission layer and requests a path from the bot's current node to that goal.
- Waits for the planner's done, then parses the packed 10-slot path, which is stored goal-first.
- Streams the hops to the motion controller in travel order (start to goal) over a valid/ready handshake, tracking the current node as each hop is accepted.

---
 rtl/path_executor.sv | 175 +++++++++++++++++
 tb/tb_path_executor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/path_executor.sv
// path_executor: requests a path from the planner and streams its hops to the motion controller
module path_executor #(
    parameter int NODE_W    = 5,
    parameter int MAX_HOPS  = 10,
    parameter int NUM_NODES = 26,
    parameter int SENTINEL  = 27,
    parameter int HOME_NODE = 0,
    parameter int TIMEOUT   = 2047
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       goal_valid,
    input  logic [NODE_W-1:0]          goal_node,
    output logic                       goal_ready,
    output logic                       plan_start,
    output logic [NODE_W-1:0]          plan_s_node,
    output logic [NODE_W-1:0]          plan_e_node,
    input  logic                       plan_done,
    input  logic [NODE_W*MAX_HOPS-1:0] plan_path,
    output logic                       node_valid,
    output logic [NODE_W-1:0]          node_out,
    input  logic                       node_ready,
    output logic [3:0]                 hop_idx,
    output logic [NODE_W-1:0]          cur_node,
    output logic                       busy,
    output logic                       arrived,
    output logic                       error
);
    localparam int LW = $clog2(MAX_HOPS + 1);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [NODE_W-1:0] NN = NODE_W'(NUM_NODES);
    localparam logic [NODE_W-1:0] SN = NODE_W'(SENTINEL);
    localparam logic [NODE_W-1:0] HN = NODE_W'(HOME_NODE);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_CLR, WAIT_DONE, PARSE, STREAM, FINISH} state_t;

    state_t                     state_q, state_d;
    logic [NODE_W*MAX_HOPS-1:0] path_q, path_d;
    logic [NODE_W-1:0]          cur_q, cur_d, s_q, s_d, e_q, e_d, out_q, out_d;
    logic [3:0]                 hop_q, hop_d;
    logic [LW-1:0]              ptr_q, ptr_d;
    logic [TW-1:0]              tmr_q, tmr_d;
    logic                       start_q, start_d, valid_q, valid_d, arr_q, arr_d, err_q, err_d;
    logic                       busy_q, busy_d, ready_q, ready_d;
    logic [NODE_W-1:0]          slot [MAX_HOPS];
    logic [LW-1:0]              len, last;

    // path is stored goal-first; len is the first slot that is not a real node
    always_comb begin
        len = LW'(MAX_HOPS);
        for (int k = MAX_HOPS - 1; k >= 0; k--) begin
            slot[k] = path_q[k*NODE_W +: NODE_W];
            if (slot[k] >= NN || slot[k] == SN) len = LW'(k);
        end
        last = (len == '0) ? '0 : len - LW'(1);
    end

    always_comb begin
        state_d = state_q;
        path_d  = path_q;
        cur_d   = cur_q;
        s_d     = s_q;
        e_d     = e_q;
        out_d   = out_q;
        hop_d   = hop_q;
        ptr_d   = ptr_q;
        tmr_d   = tmr_q;
        valid_d = valid_q;
        start_d = 1'b0;
        arr_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (goal_valid) begin
                if (goal_node >= NN) err_d = 1'b1;
                else if (goal_node == cur_q) arr_d = 1'b1;
                else begin
                    s_d     = cur_q;
                    e_d     = goal_node;
                    tmr_d   = '0;
                    start_d = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                tmr_d   = tmr_q + TW'(1);
                state_d = WAIT_CLR;
            end
            WAIT_CLR, WAIT_DONE: begin
                tmr_d = tmr_q + TW'(1);
                if (state_q == WAIT_CLR && !plan_done) state_d = WAIT_DONE;
                else if (state_q == WAIT_DONE && plan_done) begin
                    path_d  = plan_path;
                    state_d = PARSE;
                end else if (tmr_q >= TMO) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            PARSE: if (len < LW'(2) || slot[0] != e_q || slot[last] != cur_q) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                ptr_d   = len - LW'(2);
                out_d   = slot[len - LW'(2)];
                hop_d   = '0;
                valid_d = 1'b1;
                state_d = STREAM;
            end
            STREAM: if (node_ready) begin
                cur_d = out_q;
                hop_d = hop_q + 4'd1;
                if (ptr_q == '0) begin
                    valid_d = 1'b0;
                    arr_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    ptr_d = ptr_q - LW'(1);
                    out_d = slot[ptr_q - LW'(1)];
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d  = state_d != IDLE;
        ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            path_q  <= '0;
            cur_q   <= HN;
            s_q     <= '0;
            e_q     <= '0;
            out_q   <= '0;
            hop_q   <= '0;
            ptr_q   <= '0;
            tmr_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            arr_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            path_q  <= path_d;
            cur_q   <= cur_d;
            s_q     <= s_d;
            e_q     <= e_d;
            out_q   <= out_d;
            hop_q   <= hop_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
            start_q <= start_d;
            valid_q <= valid_d;
            arr_q   <= arr_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign goal_ready  = ready_q;
    assign plan_start  = start_q;
    assign plan_s_node = s_q;
    assign plan_e_node = e_q;
    assign node_valid  = valid_q;
    assign node_out    = out_q;
    assign hop_idx     = hop_q;
    assign cur_node    = cur_q;
    assign busy        = busy_q;
    assign arrived     = arr_q;
    assign error       = err_q;
endmodule

// File: tb/tb_path_executor.sv
// tb_path_executor: directed checks of path_executor with a hand-driven planner and motion controller
module tb_path_executor;
    localparam int TIMEOUT = 2047;

    logic        clk = 1'b0, rst = 1'b0, goal_valid = 1'b0, plan_done = 1'b0, node_ready = 1'b0;
    logic [4:0]  goal_node = '0;
    logic [49:0] plan_path = '0;
    logic        goal_ready, plan_start, node_valid, busy, arrived, error;
    logic [4:0]  plan_s_node, plan_e_node, node_out, cur_node;
    logic [3:0]  hop_idx;
    int          total = 0, passed = 0;

    logic [4:0] h_a [9] = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9};
    logic [4:0] h_b [9] = '{5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd0, 5'd1};

    path_executor #(.HOME_NODE(1), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .goal_valid(goal_valid), .goal_node(goal_node), .goal_ready(goal_ready),
        .plan_start(plan_start), .plan_s_node(plan_s_node), .plan_e_node(plan_e_node),
        .plan_done(plan_done), .plan_path(plan_path), .node_valid(node_valid), .node_out(node_out),
        .node_ready(node_ready), .hop_idx(hop_idx), .cur_node(cur_node), .busy(busy),
        .arrived(arrived), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic request(input logic [4:0] g, input logic [4:0] s, input logic [49:0] path, input int dly);
        logic bad;
        goal_node = g;
        goal_valid = 1'b1;
        @(negedge clk);
        goal_valid = 1'b0;
        chk("plan_start", plan_start, 1);
        chk("plan_s", plan_s_node, s);
        chk("plan_e", plan_e_node, g);
        @(negedge clk);
        chk("start_one_cycle", plan_start, 0);
        plan_done = 1'b0;
        goal_node = s;
        goal_valid = 1'b1;
        bad = 1'b0;
        repeat (dly) begin
            @(negedge clk);
            bad |= node_valid | error | arrived | plan_start;
        end
        goal_valid = 1'b0;
        chk("wait_quiet", bad, 0);
        chk("wait_busy", busy, 1);
        plan_path = path;
        plan_done = 1'b1;
    endtask

    task automatic hop(input logic [4:0] n, input int i, input int bp);
        int w = 0;
        while (!node_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("hop_valid", node_valid, 1);
        chk("hop_node", node_out, n);
        chk("hop_idx", hop_idx, i);
        repeat (bp) begin
            @(negedge clk);
            chk("bp_node", node_out, n);
            chk("bp_idx", hop_idx, i);
        end
        node_ready = 1'b1;
        @(negedge clk);
        node_ready = 1'b0;
        chk("cur_node", cur_node, n);
    endtask

    task automatic mal_check();
        int e = 0;
        logic v = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (error) e++;
            v |= node_valid;
        end
        chk("mal_err_pulses", e, 1);
        chk("mal_no_valid", v, 0);
        chk("mal_cur", cur_node, 1);
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cur", cur_node, 1);
        chk("rst_ready", goal_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", node_valid, 0);
        chk("rst_start", plan_start, 0);
        chk("rst_out", node_out, 0);
        chk("rst_idx", hop_idx, 0);
        chk("rst_flags", {arrived, error}, 0);
        rst = 1'b0;
        @(negedge clk);

        request(5, 1, {{7{5'd27}}, 5'd1, 5'd2, 5'd5}, 2);
        hop(2, 0, 0);
        hop(5, 1, 0);
        chk("t1_arrived", arrived, 1);
        chk("t1_valid_drop", node_valid, 0);
        @(negedge clk);
        chk("t1_arrived_pulse", arrived, 0);
        chk("t1_idle", goal_ready, 1);

        plan_path = {10{5'd27}};
        request(1, 5, {{7{5'd27}}, 5'd5, 5'd2, 5'd1}, 40);
        hop(2, 0, 3);
        hop(1, 1, 3);
        chk("t2_arrived", arrived, 1);
        @(negedge clk);

        request(5, 1, {{9{5'd27}}, 5'd4}, 3);
        mal_check();
        request(5, 1, {{7{5'd27}}, 5'd3, 5'd2, 5'd5}, 3);
        mal_check();

        goal_node = 1;
        goal_valid = 1'b1;
        @(negedge clk);
        goal_valid = 1'b0;
        chk("same_arrived", arrived, 1);
        chk("same_no_start", plan_start, 0);
        chk("same_busy", busy, 0);
        @(negedge clk);
        chk("same_pulse", arrived, 0);
        goal_node = 30;
        goal_valid = 1'b1;
        @(negedge clk);
        goal_valid = 1'b0;
        chk("bad_goal_err", error, 1);
        chk("bad_goal_busy", busy, 0);
        @(negedge clk);
        chk("bad_goal_pulse", error, 0);

        plan_done = 1'b0;
        goal_node = 5;
        goal_valid = 1'b1;
        @(negedge clk);
        goal_valid = 1'b0;
        chk("to_start", plan_start, 1);
        n = 0;
        while (!error && n < 2100) begin
            @(negedge clk);
            n++;
        end
        chk("to_err", error, 1);
        chk("to_window", (n >= TIMEOUT && n <= TIMEOUT + 4), 1);
        @(negedge clk);
        chk("to_idle", goal_ready, 1);

        request(9, 1, {5'd1, 5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9}, 2);
        for (int i = 0; i < 9; i++) hop(h_a[i], i, 0);
        chk("full_arrived", arrived, 1);
        chk("full_cur", cur_node, 9);
        @(negedge clk);

        request(1, 9, {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd0, 5'd1}, 2);
        for (int i = 0; i < 2; i++) hop(h_b[i], i, 0);
        chk("mid_valid", node_valid, 1);
        chk("mid_idx", hop_idx, 2);
        rst = 1'b1;
        #1;
        chk("mr_valid", node_valid, 0);
        chk("mr_cur", cur_node, 1);
        chk("mr_idx", hop_idx, 0);
        chk("mr_out", node_out, 0);
        chk("mr_busy", busy, 0);
        chk("mr_plan", {plan_start, plan_s_node, plan_e_node}, 0);
        @(negedge clk);
        rst = 1'b0;
        node_ready = 1'b1;
        repeat (3) @(negedge clk);
        node_ready = 1'b0;
        chk("idle_ready_noeffect", cur_node, 1);
        chk("idle_no_valid", node_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
